// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a byte-serial load/store engine on an 8-bit synchronous RAM.
// Build macro MISALIGN_TRAP_EN adds misalign_o and traps unaligned halfword/word accesses.
module mem_stage #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        mem_op_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  output logic              stall_req_o,
  output logic              valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   r = f3[2] ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [31:0]         sdata_q, sdata_d;
  logic [31:0]         ldata_q, ldata_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          lwd_q, lwd_d;
  logic                lwreg_q, lwreg_d;
  logic                valid_q, valid_d;
  logic [4:0]          wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                misalign_d;

  logic                is_mem, is_ld, misaligned;
  logic [2:0]          n_i, n_q;
  logic [1:0]          byte_idx;
  logic [31:0]         ld_word;
  logic                stall_c, wr_c;
  logic [RAM_AW-1:0]   ram_addr_c;
  logic [7:0]          dout_c;
  logic                unused_addr;

  // ld and st both set (or neither) decodes as a non-memory op.
  assign is_ld  = mem_op_i[4];
  assign is_mem = mem_op_i[4] ^ mem_op_i[3];
  assign n_i    = size_bytes(mem_op_i[1:0]);
  assign n_q    = size_bytes(f3_q[1:0]);
  assign unused_addr = ^mem_addr_i;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (mem_op_i[1:0] == 2'b01 && mem_addr_i[0]) ||
                      (mem_op_i[1] && mem_addr_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Byte captured this cycle belongs to the address driven one cycle earlier.
  assign byte_idx = 2'(cnt_q[1:0] - 2'd1);
  always_comb begin
    ld_word = ldata_q;
    ld_word[{byte_idx, 3'b000} +: 8] = ram_din_i;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    ldata_d    = ldata_q;
    f3_d       = f3_q;
    lwd_d      = lwd_q;
    lwreg_d    = lwreg_q;
    valid_d    = 1'b0;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    misalign_d = 1'b0;
    stall_c    = 1'b0;
    wr_c       = 1'b0;
    dout_c     = 8'h00;
    ram_addr_c = mem_addr_i[RAM_AW-1:0];

    case (state_q)
      IDLE: begin
        if (valid_i && is_mem && !misaligned) begin
          addr_d  = mem_addr_i[RAM_AW-1:0];
          sdata_d = mem_sdata_i;
          ldata_d = 32'h0;
          f3_d    = mem_op_i[2:0];
          lwd_d   = wd_i;
          lwreg_d = wreg_i;
          cnt_d   = 3'd1;
          if (is_ld) begin
            stall_c = 1'b1;
            state_d = LOAD;
          end else begin
            wr_c   = 1'b1;
            dout_c = mem_sdata_i[7:0];
            if (n_i == 3'd1) begin
              // SB completes in the accept cycle.
              valid_d = 1'b1;
              wd_d    = wd_i;
              wreg_d  = 1'b0;
              wdata_d = 32'h0;
              cnt_d   = 3'd0;
            end else begin
              stall_c = 1'b1;
              state_d = STORE;
            end
          end
        end else if (valid_i && is_mem) begin
          valid_d    = 1'b1;
          wd_d       = wd_i;
          wreg_d     = 1'b0;
          wdata_d    = 32'h0;
          misalign_d = 1'b1;
        end else begin
          valid_d = valid_i;
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          wdata_d = wdata_i;
        end
      end

      LOAD: begin
        ram_addr_c = addr_q + RAM_AW'(cnt_q);
        ldata_d    = ld_word;
        stall_c    = (cnt_q < n_q);
        if (cnt_q == n_q) begin
          valid_d = 1'b1;
          wd_d    = lwd_q;
          wreg_d  = lwreg_q;
          wdata_d = load_extend(ld_word, f3_q);
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      STORE: begin
        ram_addr_c = addr_q + RAM_AW'(cnt_q);
        wr_c       = 1'b1;
        dout_c     = sdata_q[{cnt_q[1:0], 3'b000} +: 8];
        stall_c    = (cnt_q < n_q - 3'd1);
        if (cnt_q == n_q - 3'd1) begin
          valid_d = 1'b1;
          wd_d    = lwd_q;
          wreg_d  = 1'b0;
          wdata_d = 32'h0;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      sdata_q <= 32'h0;
      ldata_q <= 32'h0;
      f3_q    <= 3'd0;
      lwd_q   <= 5'd0;
      lwreg_q <= 1'b0;
      valid_q <= 1'b0;
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      ldata_q <= ldata_d;
      f3_q    <= f3_d;
      lwd_q   <= lwd_d;
      lwreg_q <= lwreg_d;
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
  assign misalign_o = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_d;
`endif

  // Write strobe and stall are gated by reset so nothing reaches the RAM while rst is high.
  assign stall_req_o = stall_c & ~rst;
  assign ram_wr_o    = wr_c & ~rst;
  assign ram_dout_o  = dout_c;
  assign ram_addr_o  = ram_addr_c;
  assign valid_o     = valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: byte-wide synchronous RAM model, hand-computed expected values.
module tb_mem_stage;
  localparam int RAM_AW = 17;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_LB  = 5'b10000;
  localparam logic [4:0] OP_LH  = 5'b10001;
  localparam logic [4:0] OP_LW  = 5'b10010;
  localparam logic [4:0] OP_LBU = 5'b10100;
  localparam logic [4:0] OP_SB  = 5'b01000;
  localparam logic [4:0] OP_SH  = 5'b01001;
  localparam logic [4:0] OP_SW  = 5'b01010;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_i = 1'b0;
  logic [4:0]        wd_i = '0;
  logic              wreg_i = 1'b0;
  logic [31:0]       wdata_i = '0;
  logic [4:0]        mem_op_i = '0;
  logic [31:0]       mem_addr_i = '0;
  logic [31:0]       mem_sdata_i = '0;
  logic              stall_req_o, valid_o, wreg_o, ram_wr_o;
  logic [4:0]        wd_o;
  logic [31:0]       wdata_o;
  logic [RAM_AW-1:0] ram_addr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i = '0;
`ifdef MISALIGN_TRAP_EN
  logic              misalign_o;
`endif

  logic [7:0] mem [2**RAM_AW];
  bit         loaded = 1'b0;
  int         passed = 0;
  int         total  = 0;

  mem_stage #(.RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i), .stall_req_o(stall_req_o), .valid_o(valid_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
`ifdef MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after its address; preloaded once.
  always @(posedge clk) begin
    if (!loaded) begin
      mem[17'h00100] = 8'h78; mem[17'h00101] = 8'h56;
      mem[17'h00102] = 8'h34; mem[17'h00103] = 8'h12;
      mem[17'h00010] = 8'h80; mem[17'h00011] = 8'hFF;
      mem[17'h00000] = 8'h00; mem[17'h1FFFF] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        mem[17'h00200 + i] = 8'h00;
        mem[17'h00400 + i] = 8'h00;
      end
      mem[17'h00300] = 8'h00;
      loaded = 1'b1;
    end
    ram_din_i <= mem[ram_addr_o];
    if (ram_wr_o) mem[ram_addr_o] = ram_dout_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] wd, input logic wr,
                       input logic [31:0] wdata);
    valid_i = v; mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
    wd_i = wd; wreg_i = wr; wdata_i = wdata;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic hold();
    @(negedge clk);
    #1;
  endtask

  initial begin
    nop();
    // Reset: a valid SW presented during reset must not write or stall.
    @(negedge clk);
    drive(1'b1, OP_SW, 32'h200, 32'hCAFEF00D, 5'd1, 1'b1, 32'h0);
    check("rst_stall", stall_req_o, 1'b0);
    check("rst_wr", ram_wr_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_wd", wd_o, 5'd0);
    check("rst_wreg", wreg_o, 1'b0);
    check("rst_wdata", wdata_o, 32'h0);
    @(negedge clk); rst = 1'b0; nop();
    check("rst_valid2", valid_o, 1'b0);

    // ADD pass-through.
    @(negedge clk); drive(1'b1, OP_ADD, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234);
    check("add_stall", stall_req_o, 1'b0);
    @(negedge clk); nop();
    check("add_valid", valid_o, 1'b1);
    check("add_wd", wd_o, 5'd5);
    check("add_wreg", wreg_o, 1'b1);
    check("add_wdata", wdata_o, 32'h0000_1234);
    @(negedge clk); nop();
    check("add_pulse", valid_o, 1'b0);

    // LW 0x100: stall cycles 0..3, result in cycle 5.
    @(negedge clk); drive(1'b1, OP_LW, 32'h100, 32'h0, 5'd10, 1'b1, 32'h0);
    check("lw_stall0", stall_req_o, 1'b1);
    check("lw_addr0", ram_addr_o, 17'h100);
    check("lw_wr0", ram_wr_o, 1'b0);
    for (int b = 1; b < 4; b++) begin
      hold();
      check("lw_stall", stall_req_o, 1'b1);
      check("lw_addr", ram_addr_o, 17'h100 + b);
      check("lw_bubble", valid_o, 1'b0);
    end
    hold();
    check("lw_stall4", stall_req_o, 1'b0);
    @(negedge clk); nop();
    check("lw_valid", valid_o, 1'b1);
    check("lw_wd", wd_o, 5'd10);
    check("lw_wdata", wdata_o, 32'h1234_5678);

    // LB / LBU / LH sign and zero extension.
    @(negedge clk); drive(1'b1, OP_LB, 32'h10, 32'h0, 5'd2, 1'b1, 32'h0);
    check("lb_stall0", stall_req_o, 1'b1);
    hold();
    check("lb_stall1", stall_req_o, 1'b0);
    @(negedge clk); nop();
    check("lb_wdata", wdata_o, 32'hFFFF_FF80);
    @(negedge clk); drive(1'b1, OP_LBU, 32'h10, 32'h0, 5'd2, 1'b1, 32'h0);
    hold();
    @(negedge clk); nop();
    check("lbu_wdata", wdata_o, 32'h0000_0080);
    @(negedge clk); drive(1'b1, OP_LH, 32'h10, 32'h0, 5'd4, 1'b1, 32'h0);
    check("lh_stall0", stall_req_o, 1'b1);
    hold();
    check("lh_stall1", stall_req_o, 1'b1);
    check("lh_addr1", ram_addr_o, 17'h11);
    hold();
    check("lh_stall2", stall_req_o, 1'b0);
    @(negedge clk); nop();
    check("lh_valid", valid_o, 1'b1);
    check("lh_wdata", wdata_o, 32'hFFFF_FF80);

    // SW 0x200: EF BE AD DE on cycles 0..3, valid in cycle 4 with wreg forced 0.
    @(negedge clk); drive(1'b1, OP_SW, 32'h200, 32'hDEAD_BEEF, 5'd6, 1'b1, 32'h0);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] sw_data;
      sw_data = 32'hDEAD_BEEF;
      if (b > 0) hold();
      check("sw_wr", ram_wr_o, 1'b1);
      check("sw_addr", ram_addr_o, 17'h200 + b);
      check("sw_dout", ram_dout_o, sw_data[8*b +: 8]);
      check("sw_stall", stall_req_o, (b < 3) ? 1'b1 : 1'b0);
    end
    @(negedge clk); nop();
    check("sw_valid", valid_o, 1'b1);
    check("sw_wreg", wreg_o, 1'b0);
    check("sw_wr_idle", ram_wr_o, 1'b0);
    check("sw_mem", {mem[17'h203], mem[17'h202], mem[17'h201], mem[17'h200]}, 32'hDEAD_BEEF);

    // SH at the top of the RAM wraps to address 0.
    @(negedge clk); drive(1'b1, OP_SH, 32'h0001_FFFF, 32'h0000_A55A, 5'd7, 1'b1, 32'h0);
    check("sh_addr0", ram_addr_o, 17'h1FFFF);
    check("sh_dout0", ram_dout_o, 8'h5A);
    check("sh_stall0", stall_req_o, 1'b1);
    hold();
    check("sh_addr1", ram_addr_o, 17'h00000);
    check("sh_dout1", ram_dout_o, 8'hA5);
    check("sh_stall1", stall_req_o, 1'b0);
    @(negedge clk); nop();
    check("sh_valid", valid_o, 1'b1);
    check("sh_mem", {mem[17'h00000], mem[17'h1FFFF]}, 16'hA55A);

    // SB never stalls; an ADD right behind it is accepted immediately.
    @(negedge clk); drive(1'b1, OP_SB, 32'h300, 32'h0000_0077, 5'd3, 1'b1, 32'h0);
    check("sb_stall", stall_req_o, 1'b0);
    check("sb_wr", ram_wr_o, 1'b1);
    check("sb_dout", ram_dout_o, 8'h77);
    @(negedge clk); drive(1'b1, OP_ADD, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0000_0ABC);
    check("sb_valid", valid_o, 1'b1);
    check("sb_wreg", wreg_o, 1'b0);
    check("sb_wd", wd_o, 5'd3);
    @(negedge clk); nop();
    check("add2_valid", valid_o, 1'b1);
    check("add2_wd", wd_o, 5'd9);
    check("add2_wdata", wdata_o, 32'h0000_0ABC);

    // Reset in cycle 1 of a SW: only byte 0 lands, then an ADD completes normally.
    @(negedge clk); drive(1'b1, OP_SW, 32'h400, 32'h1122_3344, 5'd8, 1'b1, 32'h0);
    check("abort_wr0", ram_wr_o, 1'b1);
    @(negedge clk); rst = 1'b1; #1;
    check("abort_wr1", ram_wr_o, 1'b0);
    check("abort_stall1", stall_req_o, 1'b0);
    @(negedge clk); rst = 1'b0; nop();
    check("abort_valid", valid_o, 1'b0);
    check("abort_wdata", wdata_o, 32'h0);
    hold();
    check("abort_no_valid", valid_o, 1'b0);
    @(negedge clk); drive(1'b1, OP_ADD, 32'h0, 32'h0, 5'd7, 1'b1, 32'h0000_0055);
    @(negedge clk); nop();
    check("post_valid", valid_o, 1'b1);
    check("post_wdata", wdata_o, 32'h0000_0055);
    check("abort_mem", {mem[17'h403], mem[17'h402], mem[17'h401], mem[17'h400]}, 32'h0000_0044);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
